// File: rtl/ks_add_arbiter_pkg.sv
// ============================================================================
// Module  : ks_add_arbiter_pkg
// Purpose : Shared constants and helpers for the shared-adder arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ks_add_arbiter_pkg;

  // Adder latency of the registered Kogge-Stone adder this block is paired with.
  localparam int DEFAULT_ADD_LAT = 3;

  // Requester index width; at least one bit even for a single requester.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin picker. Scans ptr, ptr+1, ... mod N and
//           grants the first active request. Never grants an idle slot.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import ks_add_arbiter_pkg::*;
#(
  parameter  int N    = 4,
  localparam int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            gnt_any
);

  // One extra bit so ptr+j can be wrapped against N without overflow.
  logic [ID_W:0] cand;

  // Rotating priority scan starting at ptr; first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int j = 0; j < N; j++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(j);
      if (cand >= (ID_W+1)'(N)) begin
        cand = cand - (ID_W+1)'(N);
      end
      if (!gnt_any && req[cand[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
    gnt[gnt_idx] = gnt_any;
  end

endmodule

`default_nettype wire

// File: rtl/ks_add_arbiter.sv
// ============================================================================
// Module  : ks_add_arbiter
// Purpose : Shares one pipelined adder among N_REQ requesters. Round-robin
//           grant, one issue per cycle, and a tag pipeline matched to the
//           adder latency that routes each sum back to its issuer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ks_add_arbiter
  import ks_add_arbiter_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int W       = 64,
  parameter  int ADD_LAT = DEFAULT_ADD_LAT,
  localparam int ID_W    = id_width(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ-1:0]   req_cin,
  output logic [W-1:0]       add_a,
  output logic [W-1:0]       add_b,
  output logic               add_cin,
  input  logic [W-1:0]       add_sum,
  input  logic               add_cout,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [W-1:0]       rsp_sum,
  output logic               rsp_cout,
  output logic               busy
);

  logic [ID_W-1:0]  rr_ptr;
  logic [N_REQ-1:0] req_masked;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any;

  // One {valid,id} per adder stage; the tail lines up with add_sum/add_cout.
  logic [ADD_LAT-1:0] tag_valid;
  logic [ID_W-1:0]    tag_id [ADD_LAT];

  // Nothing may be granted while reset is held.
  assign req_masked = rst ? '0 : req_valid;

  rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
    .req     (req_masked),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;

  // Route the granted requester's operands to the adder; zeros when idle.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        add_a   = req_a[i*W +: W];
        add_b   = req_b[i*W +: W];
        add_cin = req_cin[i];
      end
    end
  end

  // Priority moves to the slot just after the last winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  // Tag shift register tracking which requester owns each adder stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
      for (int k = 0; k < ADD_LAT; k++) begin
        tag_id[k] <= '0;
      end
    end else begin
      tag_valid[0] <= gnt_any;
      tag_id[0]    <= gnt_idx;
      for (int k = 1; k < ADD_LAT; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_id[k]    <= tag_id[k-1];
      end
    end
  end

  // Response register; data holds between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      rsp_valid <= tag_valid[ADD_LAT-1];
      rsp_id    <= tag_id[ADD_LAT-1];
      if (tag_valid[ADD_LAT-1]) begin
        rsp_sum  <= add_sum;
        rsp_cout <= add_cout;
      end
    end
  end

  assign busy = (|tag_valid) | rsp_valid;

endmodule

`default_nettype wire

// File: tb/tb_ks_add_arbiter.sv
// ============================================================================
// Module  : tb_ks_add_arbiter
// Purpose : Scoreboard bench for ks_add_arbiter with a behavioural 3-stage
//           adder model and a rotation-order grant reference.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ks_add_arbiter;
  import ks_add_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int W   = 64;
  localparam int LAT = 3;
  localparam int IDW = id_width(N);

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_cin;
  logic [W-1:0]   add_sum;
  logic           add_cout;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic           busy;

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  logic         op_c [N];

  typedef struct {
    int         id;
    logic [W:0] res;
    int         due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   grant_log[$];
  int   mp = 0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   kcnt [N];

  always #5 clk = ~clk;

  // Pack the per-requester operand arrays onto the port buses.
  always_comb begin
    req_a   = '0;
    req_b   = '0;
    req_cin = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
      req_cin[i]      = op_c[i];
    end
  end

  // Behavioural adder: LAT register stages from operands to sum.
  logic [W:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign add_sum  = pipe[LAT-1][W-1:0];
  assign add_cout = pipe[LAT-1][W];

  // Cycle counter used for response-latency checks.
  always @(posedge clk) cyc = cyc + 1;

  ks_add_arbiter #(.N_REQ(N), .W(W), .ADD_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got rsp_id %0d sum %0h, expected no response", rsp_id, rsp_sum);
      end else begin
        mon_e = sbq.pop_front();
        check("rsp_id", {{(W+1-IDW){1'b0}}, rsp_id}, mon_e.id[W:0]);
        check("rsp_sum", {rsp_cout, rsp_sum}, mon_e.res);
        check("rsp_latency", cyc[W:0], mon_e.due[W:0]);
      end
    end
  end

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    op_a[i] = a;
    op_b[i] = b;
    op_c[i] = c;
  endtask

  // One clock: check the grant against the rotation model, log expectations.
  task automatic step(output int g);
    logic [N-1:0] expm;
    @(negedge clk);
    g = -1;
    if (!rst) begin
      for (int j = 0; j < N; j++) begin
        int k;
        k = (mp + j) % N;
        if (g < 0 && req_valid[k]) g = k;
      end
    end
    expm = '0;
    if (g >= 0) expm[g] = 1'b1;
    check("req_ready", {{(W+1-N){1'b0}}, req_ready}, {{(W+1-N){1'b0}}, expm});
    for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
    if (g >= 0) begin
      check("add_a", {1'b0, add_a}, {1'b0, op_a[g]});
      sbq.push_back('{g, {1'b0, op_a[g]} + {1'b0, op_b[g]} + {{W{1'b0}}, op_c[g]}, cyc + 1 + LAT});
      mp = (g + 1) % N;
    end else begin
      check("add_a_idle", {1'b0, add_a}, '0);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      sbq.delete();
      mp = 0;
    end
  endtask

  task automatic drain();
    int g;
    req_valid = '0;
    for (int i = 0; i < LAT + 6 && sbq.size() > 0; i++) step(g);
    check("drain_empty", sbq.size(), '0);
    step(g);
    check("busy_idle", {{W{1'b0}}, busy}, '0);
  endtask

  task automatic refresh_ctr(input int i);
    set_op(i, W'(i*16 + kcnt[i]), W'(kcnt[i]), kcnt[i][0]);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    rst = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) set_op(i, '0, '0, 1'b0);

    // Reset state: no grants while rst, all outputs zero.
    step(g);
    step(g);
    check("rst_rsp_valid", {{W{1'b0}}, rsp_valid}, '0);
    check("rst_rsp_id", {{(W+1-IDW){1'b0}}, rsp_id}, '0);
    check("rst_rsp_sum", {rsp_cout, rsp_sum}, '0);
    check("rst_busy", {{W{1'b0}}, busy}, '0);
    rst = 1'b0;
    req_valid = '0;

    // Single op on requester 2: carry ripples all the way out.
    set_op(2, {W{1'b1}}, W'(1), 1'b0);
    req_valid = 4'b0100;
    step(g);
    req_valid = '0;
    step(g);
    check("busy_inflight", {{W{1'b0}}, busy}, 1);
    drain();

    // Full contention from reset: strict rotation 0,1,2,3,...
    rst = 1'b1;
    step(g);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin kcnt[i] = 0; refresh_ctr(i); end
    req_valid = '1;
    grant_log.delete();
    for (int n = 0; n < 8; n++) begin
      step(g);
      if (g >= 0) begin kcnt[g]++; refresh_ctr(g); end
    end
    req_valid = '0;
    check("rot_count", grant_log.size(), 8);
    for (int n = 0; n < 8 && n < grant_log.size(); n++) check("rot_order", grant_log[n], n % N);
    drain();

    // Holes: move pointer to 2 by granting req 1, then 1 and 3 compete.
    req_valid = 4'b0010;
    step(g);
    if (g >= 0) begin kcnt[g]++; refresh_ctr(g); end
    req_valid = 4'b1010;
    grant_log.delete();
    for (int n = 0; n < 3; n++) begin
      step(g);
      if (g >= 0) begin kcnt[g]++; refresh_ctr(g); end
    end
    req_valid = '0;
    check("holes_count", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      check("holes_0", grant_log[0], 3);
      check("holes_1", grant_log[1], 1);
      check("holes_2", grant_log[2], 3);
    end
    drain();

    // Back-to-back on requester 0: ten consecutive responses.
    for (int k = 0; k < 10; k++) begin
      set_op(0, W'(k), W'(k), 1'b1);
      req_valid = 4'b0001;
      step(g);
    end
    req_valid = '0;
    drain();

    // Randomized traffic; operands held until granted, drops allowed.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(1, 0) == 1) begin
            set_op(i, ($urandom_range(3, 0) == 0) ? {W{1'b1}} : {$urandom, $urandom},
                   {$urandom, $urandom}, 1'($urandom));
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(7, 0) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      step(g);
      if (g >= 0) req_valid[g] = 1'b0;
    end
    drain();

    // Reset mid-flight: three issued ops must never respond.
    for (int i = 0; i < 3; i++) set_op(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    req_valid = 4'b0111;
    for (int n = 0; n < 3; n++) begin
      step(g);
      if (g >= 0) req_valid[g] = 1'b0;
    end
    rst = 1'b1;
    step(g);
    rst = 1'b0;
    check("post_rst_busy", {{W{1'b0}}, busy}, '0);
    for (int n = 0; n < LAT + 3; n++) step(g);
    set_op(1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
    req_valid = 4'b0010;
    step(g);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
